// File: rtl/config_reg_master.sv
`default_nettype none
// ============================================================================
// Module  : config_reg_master
// Brief   : Single-command bus initiator for the 8 x 16-bit ADC config
//           register block (read, write, write-with-verify).
// Revision: 1.0  initial release
// ============================================================================
module config_reg_master #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              reg_write,
    output logic [ADDR_W-1:0] reg_address,
    output logic [DATA_W-1:0] reg_data_in,
    input  logic [DATA_W-1:0] reg_data_out,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WRITE   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_RESP    = 3'd4
    } state_t;

    localparam logic [1:0] c_op_write   = 2'b01;
    localparam logic [1:0] c_op_wverify = 2'b10;
    localparam logic [2:0] c_lat_load   = 3'(RD_LAT - 1);

    state_t              state_q, state_d;
    logic [2:0]          cnt_q, cnt_d;
    logic [1:0]          op_q, op_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q, rsp_err_d;
    logic                reg_write_q, reg_write_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                cmd_ready_q, cmd_ready_d;
    logic                busy_q, busy_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    op_d    = cmd_op;
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                    if (cmd_op == c_op_write || cmd_op == c_op_wverify) begin
                        state_d = ST_WRITE;
                    end else begin
                        // reserved op 11 falls through here and behaves as a read
                        state_d = ST_WAIT;
                        cnt_d   = c_lat_load;
                    end
                end
            end
            ST_WRITE: begin
                if (op_q == c_op_wverify) begin
                    state_d = ST_WAIT;
                    cnt_d   = c_lat_load;
                end else begin
                    state_d     = ST_RESP;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b0;
                end
            end
            ST_WAIT: begin
                // counter is only decremented while non-zero, so it never wraps
                if (cnt_q == 3'd0) begin
                    state_d = ST_CAPTURE;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            ST_CAPTURE: begin
                rsp_rdata_d = reg_data_out;
                rsp_err_d   = (op_q == c_op_wverify) && (reg_data_out != wdata_q);
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Strobes are registered copies of the next state so they are glitch-free.
        reg_write_d = (state_d == ST_WRITE);
        rsp_valid_d = (state_d == ST_RESP);
        cmd_ready_d = (state_d == ST_IDLE);
        busy_d      = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 3'd0;
            op_q        <= 2'b00;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            reg_write_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            reg_write_q <= reg_write_d;
            rsp_valid_q <= rsp_valid_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign busy        = busy_q;
    assign reg_write   = reg_write_q;
    assign reg_address = addr_q;
    assign reg_data_in = wdata_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_config_reg_master.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : tb_config_reg_master
// Brief   : Scoreboard bench; dut0 uses RD_LAT=1, dut1 uses RD_LAT=3.
// Revision: 1.0  initial release
// ============================================================================
module tb_config_reg_master;

    localparam int DW = 16;
    localparam int AW = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic          cmd_valid    [2];
    logic          cmd_ready    [2];
    logic [1:0]    cmd_op       [2];
    logic [AW-1:0] cmd_addr     [2];
    logic [DW-1:0] cmd_wdata    [2];
    logic          reg_write    [2];
    logic [AW-1:0] reg_address  [2];
    logic [DW-1:0] reg_data_in  [2];
    logic [DW-1:0] reg_data_out [2];
    logic          rsp_valid    [2];
    logic [DW-1:0] rsp_rdata    [2];
    logic          rsp_err      [2];
    logic          busy         [2];

    config_reg_master #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(1)) dut0 (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]), .cmd_op(cmd_op[0]),
        .cmd_addr(cmd_addr[0]), .cmd_wdata(cmd_wdata[0]),
        .reg_write(reg_write[0]), .reg_address(reg_address[0]),
        .reg_data_in(reg_data_in[0]), .reg_data_out(reg_data_out[0]),
        .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]),
        .busy(busy[0])
    );

    config_reg_master #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(3)) dut1 (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]), .cmd_op(cmd_op[1]),
        .cmd_addr(cmd_addr[1]), .cmd_wdata(cmd_wdata[1]),
        .reg_write(reg_write[1]), .reg_address(reg_address[1]),
        .reg_data_in(reg_data_in[1]), .reg_data_out(reg_data_out[1]),
        .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]),
        .busy(busy[1])
    );

    // Register block model: data_out follows the addressed word after RD_LAT cycles.
    logic [DW-1:0] mem  [2][8];
    logic [DW-1:0] pipe [2][3];
    logic          stuck0 [2];

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (reg_write[d] === 1'b1)
                mem[d][reg_address[d]] <= reg_data_in[d] & (stuck0[d] ? 16'hFFFE : 16'hFFFF);
            pipe[d][0] <= mem[d][reg_address[d]];
            pipe[d][1] <= pipe[d][0];
            pipe[d][2] <= pipe[d][1];
        end
    end
    assign reg_data_out[0] = pipe[0][0];
    assign reg_data_out[1] = pipe[1][2];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            d;
        logic [DW-1:0] rdata;
        logic          err;
        int            acc;
        int            lat;
    } rsp_t;

    typedef struct {
        int            d;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    rsp_t rsp_q[$];
    wr_t  wr_q[$];

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic fail_now(string nm);
        n_vec++;
        n_miss++;
        $display("FAIL %s: bound expired (t=%0t)", nm, $time);
    endtask

    // Monitor: pops the scoreboard whenever a DUT presents a write strobe or response.
    logic prev_wr [2];
    always @(negedge clk) begin : monitor
        rsp_t e;
        wr_t  w;
        for (int d = 0; d < 2; d++) begin
            if (reg_write[d] === 1'b1) begin
                check($sformatf("dut%0d_wr_pulse_width", d), {31'd0, prev_wr[d]}, 32'd0);
                if (wr_q.size() == 0) begin
                    fail_now($sformatf("dut%0d_unexpected_write", d));
                end else begin
                    w = wr_q.pop_front();
                    check($sformatf("dut%0d_wr_dut", d), d, w.d);
                    check($sformatf("dut%0d_wr_addr", d), {29'd0, reg_address[d]}, {29'd0, w.addr});
                    check($sformatf("dut%0d_wr_data", d), {16'd0, reg_data_in[d]}, {16'd0, w.data});
                end
            end
            if (rsp_valid[d] === 1'b1) begin
                if (rsp_q.size() == 0) begin
                    fail_now($sformatf("dut%0d_unexpected_rsp", d));
                end else begin
                    e = rsp_q.pop_front();
                    check($sformatf("dut%0d_rsp_dut", d), d, e.d);
                    check($sformatf("dut%0d_rsp_rdata", d), {16'd0, rsp_rdata[d]}, {16'd0, e.rdata});
                    check($sformatf("dut%0d_rsp_err", d), {31'd0, rsp_err[d]}, {31'd0, e.err});
                    check($sformatf("dut%0d_rsp_latency", d), cyc - e.acc + 1, e.lat);
                end
            end
            prev_wr[d] = reg_write[d];
        end
    end

    // Drives one command; hold keeps cmd_valid asserted for a following command.
    task automatic issue(int d, logic [1:0] op, logic [AW-1:0] a, logic [DW-1:0] wd,
                         logic [DW-1:0] exp_rd, logic exp_err, bit expect_rsp, bit hold);
        int   n = 0;
        int   rl;
        rsp_t e;
        wr_t  w;
        rl = (d == 0) ? 1 : 3;
        @(negedge clk);
        cmd_valid[d] = 1'b1;
        cmd_op[d]    = op;
        cmd_addr[d]  = a;
        cmd_wdata[d] = wd;
        while (cmd_ready[d] !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            fail_now($sformatf("dut%0d_accept_timeout", d));
            cmd_valid[d] = 1'b0;
            return;
        end
        if (op == 2'b01 || op == 2'b10) begin
            w.d = d; w.addr = a; w.data = wd;
            wr_q.push_back(w);
        end
        if (expect_rsp) begin
            e.d     = d;
            e.rdata = exp_rd;
            e.err   = exp_err;
            e.acc   = cyc + 1;
            e.lat   = (op == 2'b01) ? 2 : (op == 2'b10) ? rl + 3 : rl + 2;
            rsp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        if (!hold) cmd_valid[d] = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((rsp_q.size() != 0 || wr_q.size() != 0 || busy[0] !== 1'b0 || busy[1] !== 1'b0)
               && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) fail_now("drain_timeout");
        @(negedge clk);
    endtask

    task automatic check_idle(string tag, int d);
        check($sformatf("%s_dut%0d_cmd_ready", tag, d), {31'd0, cmd_ready[d]}, 32'd1);
        check($sformatf("%s_dut%0d_busy", tag, d), {31'd0, busy[d]}, 32'd0);
        check($sformatf("%s_dut%0d_reg_write", tag, d), {31'd0, reg_write[d]}, 32'd0);
        check($sformatf("%s_dut%0d_rsp_valid", tag, d), {31'd0, rsp_valid[d]}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            cmd_valid[d] = 1'b0;
            cmd_op[d]    = 2'b00;
            cmd_addr[d]  = '0;
            cmd_wdata[d] = '0;
            stuck0[d]    = 1'b0;
            prev_wr[d]   = 1'b0;
        end

        // Reset held for three cycles
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_idle("reset", 0);
        check_idle("reset", 1);

        // Plain write, all-ones data, address 0
        issue(0, 2'b01, 3'd0, 16'hFFFF, 16'h0000, 1'b0, 1'b1, 1'b0);
        drain();
        issue(1, 2'b01, 3'd0, 16'hFFFF, 16'h0000, 1'b0, 1'b1, 1'b0);
        drain();

        // Write-verify: healthy register, then bit 0 stuck low
        issue(0, 2'b10, 3'd5, 16'hA5C3, 16'hA5C3, 1'b0, 1'b1, 1'b0);
        drain();
        stuck0[0] = 1'b1;
        issue(0, 2'b10, 3'd5, 16'hA5C3, 16'hA5C2, 1'b1, 1'b1, 1'b0);
        drain();
        stuck0[0] = 1'b0;
        issue(1, 2'b10, 3'd5, 16'hA5C3, 16'hA5C3, 1'b0, 1'b1, 1'b0);
        drain();

        // Read-back at both latencies, plus reserved op behaving as read
        issue(0, 2'b01, 3'd7, 16'h1234, 16'h0000, 1'b0, 1'b1, 1'b0);
        issue(0, 2'b00, 3'd7, 16'h0000, 16'h1234, 1'b0, 1'b1, 1'b0);
        drain();
        issue(1, 2'b01, 3'd7, 16'h1234, 16'h0000, 1'b0, 1'b1, 1'b0);
        issue(1, 2'b00, 3'd7, 16'h0000, 16'h1234, 1'b0, 1'b1, 1'b0);
        issue(1, 2'b11, 3'd7, 16'hDEAD, 16'h1234, 1'b0, 1'b1, 1'b0);
        drain();

        // Four commands with cmd_valid held high throughout
        issue(0, 2'b01, 3'd2, 16'h5555, 16'h0000, 1'b0, 1'b1, 1'b1);
        issue(0, 2'b10, 3'd3, 16'h0F0F, 16'h0F0F, 1'b0, 1'b1, 1'b1);
        issue(0, 2'b00, 3'd2, 16'h0000, 16'h5555, 1'b0, 1'b1, 1'b1);
        issue(0, 2'b00, 3'd3, 16'h0000, 16'h0F0F, 1'b0, 1'b1, 1'b0);
        drain();

        // Reset while a read sits in WAIT: no response may follow
        issue(1, 2'b00, 3'd7, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_idle("post_abort", 1);
        repeat (6) @(negedge clk);
        issue(1, 2'b01, 3'd1, 16'hBEEF, 16'h0000, 1'b0, 1'b1, 1'b0);
        issue(1, 2'b00, 3'd1, 16'h0000, 16'hBEEF, 1'b0, 1'b1, 1'b0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
